rv_iopmp_error_record: RTL and testbench
========================================

# rv_iopmp_error_record

Sequential error-record stage directly downstream of the IOPMP transaction-checking logic. It consumes the combinational `rv_iopmp_pkg::error_capture_t` bundle, qualified by a one-cycle transaction-done strobe. It latches the first violation into software-visible ERR_REQINFO / ERR_REQID / ERR_REQADDR(H) state and holds it until software clears it. It drives the IOPMP interrupt and optionally counts violations lost while the record was occupied.

## Interface
- `SID_WIDTH`, 8: width of the captured source ID.
- `CNT_WIDTH`, 8: width of the lost-error counter. Only used with `RV_IOPMP_ERR_CNT_EN`.
- `clk_i`  in  1: clock. Single clock domain.
- `rst_ni`  in  1: reset. Asynchronous assertion, active-low.
- `txn_done_i`  in  1: one-cycle strobe. Marks that `err_interface_i` describes a completed check this cycle.
- `err_interface_i`  in  `error_capture_t`: bundle from the checker (`error_detected`, `ttype`, `etype`, `err_reqid.sid`, `err_reqid.eid`, `err_reqaddr`, `err_reqaddrh`).
- `intr_en_i`  in  1: ERR_CFG.ie, interrupt enable.
- `clear_i`  in  1: one-cycle software write-1 to ERR_REQINFO.v.
- `err_v_o`  out  1: record valid.
- `err_ttype_o`  out  2, `err_etype_o`  out  3: captured transaction type and error type.
- `err_sid_o`  out  `SID_WIDTH`, `err_eid_o`  out  16: captured source ID and entry index.
- `err_addr_o`  out  32, `err_addrh_o`  out  32: captured address, low and high halves.
- `irq_o`  out  1: level interrupt.
- `err_lost_cnt_o`  out  `CNT_WIDTH`: lost-error count. Reads 0 when the feature is compiled out.

## Operation
- Event `ev = txn_done_i & err_interface_i.error_detected`. Bundle fields are ignored when `ev` = 0.
- FSM has two states, EMPTY and HELD. Reset state is EMPTY.
  - EMPTY, `ev`: all fields are loaded from the bundle. Next state is HELD.
  - EMPTY, `clear_i`: no effect.
  - HELD, `ev` without `clear_i`: fields are unchanged. The lost counter increments, saturating at all-ones.
  - HELD, `clear_i` without `ev`: next state is EMPTY. The counter resets to 0. Captured fields keep their last values but are architecturally don't-care.
  - HELD, `clear_i` and `ev` in the same cycle: the new event is captured, overwriting the fields. State stays HELD. The counter resets to 0. Clear and capture both take effect, so no event is lost.
- `err_v_o` = (state == HELD).
- `irq_o` = `err_v_o & intr_en_i`, combinational on `intr_en_i`. Toggling `intr_en_i` does not alter the record.
- ttype is captured verbatim; the value 0 is never produced by the upstream stage. eid is 16 bits and is not truncated.

## Timing
- Capture latency is 1 cycle: `ev` at edge N, then `err_v_o` and the fields are valid after edge N.
- Clear latency is 1 cycle.
- `irq_o` follows `err_v_o` with 0 additional cycles.
- Reset, asynchronous mid-operation:
  - `err_v_o` = 0, `irq_o` = 0, all fields = 0, counter = 0. State is EMPTY.
  - A `txn_done_i` strobe during reset is dropped.
- `txn_done_i` held high for k cycles with an error counts as k events. The upstream stage guarantees single-cycle strobes.
- No back-pressure. Every strobe is consumed in the cycle it is presented.

## Configuration
- `RV_IOPMP_ERR_CNT_EN` defined: the `CNT_WIDTH`-bit saturating lost-error counter is implemented as described above.
- `RV_IOPMP_ERR_CNT_EN` undefined:
  - No counter flops are generated.
  - `err_lost_cnt_o` is tied to 0.
  - Events arriving while HELD are silently dropped.
  - All other behaviour is identical.

## Test plan
- Basic capture:
  - Stimulus: reset release, then `ev` with ttype=1, etype=2, sid=0x05, eid=3, addr=0x8000_1000, addrh=0x1, `intr_en_i`=1.
  - Response: next cycle `err_v_o`=1, `irq_o`=1, all fields match.
- First error wins:
  - Stimulus: capture per the basic scenario, then three further `ev`s with sid=0x07.
  - Response: fields still sid=0x05; `err_lost_cnt_o`=3 (0 with the macro undefined).
- Saturation: with `CNT_WIDTH`=2 and the record HELD, issue 5 extra `ev`s. Response: counter=3.
- Simultaneous clear and error:
  - Stimulus: while HELD with counter=2, assert `clear_i` and `ev` (sid=0x09, etype=4) in the same cycle.
  - Response: `err_v_o` stays 1, sid=0x09, etype=4, counter=0.
- Clear and interrupt gating:
  - Stimulus: with the record HELD and `intr_en_i`=0, `irq_o`=0 while `err_v_o`=1. Then pulse `clear_i`.
  - Response: next cycle `err_v_o`=0.
  - Stimulus: `ev` with `txn_done_i`=0.
  - Response: no capture.
- Asynchronous reset mid-HELD:
  - Stimulus: drop `rst_ni` between clock edges.
  - Response: all outputs 0 immediately. The first post-reset `ev` is captured normally.

Source files
------------

// File: rtl/rv_iopmp_error_record.sv
// IOPMP error record: latches the first violation and drives the interrupt.
// Optional lost-error counter enabled by defining RV_IOPMP_ERR_CNT_EN.

package rv_iopmp_pkg;

    localparam int unsigned SID_W = 8;

    typedef struct packed {
        logic [SID_W-1:0] sid;
        logic [15:0]      eid;
    } err_reqid_t;

    typedef struct packed {
        logic        error_detected;
        logic [1:0]  ttype;
        logic [2:0]  etype;
        err_reqid_t  err_reqid;
        logic [31:0] err_reqaddr;
        logic [31:0] err_reqaddrh;
    } error_capture_t;

endpackage

module rv_iopmp_error_record
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned SID_WIDTH = SID_W,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 txn_done_i,
    input  error_capture_t       err_interface_i,
    input  logic                 intr_en_i,
    input  logic                 clear_i,
    output logic                 err_v_o,
    output logic [1:0]           err_ttype_o,
    output logic [2:0]           err_etype_o,
    output logic [SID_WIDTH-1:0] err_sid_o,
    output logic [15:0]          err_eid_o,
    output logic [31:0]          err_addr_o,
    output logic [31:0]          err_addrh_o,
    output logic                 irq_o,
    output logic [CNT_WIDTH-1:0] err_lost_cnt_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   ev;
    logic   load;

    assign ev = txn_done_i & err_interface_i.error_detected;

    // Next state and capture decision; a clear with a new event recaptures.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (ev) begin
                    load    = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (clear_i) begin
                    if (ev) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Record fields; only written on capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_ttype_o <= '0;
            err_etype_o <= '0;
            err_sid_o   <= '0;
            err_eid_o   <= '0;
            err_addr_o  <= '0;
            err_addrh_o <= '0;
        end else if (load) begin
            err_ttype_o <= err_interface_i.ttype;
            err_etype_o <= err_interface_i.etype;
            err_sid_o   <= SID_WIDTH'(err_interface_i.err_reqid.sid);
            err_eid_o   <= err_interface_i.err_reqid.eid;
            err_addr_o  <= err_interface_i.err_reqaddr;
            err_addrh_o <= err_interface_i.err_reqaddrh;
        end
    end

    assign err_v_o = (state_q == HELD);
    assign irq_o   = err_v_o & intr_en_i;

`ifdef RV_IOPMP_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] lost_cnt_q;

    // Count events dropped while occupied; saturates, cleared with record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lost_cnt_q <= '0;
        end else if (state_q == HELD) begin
            if (clear_i) begin
                lost_cnt_q <= '0;
            end else if (ev && !(&lost_cnt_q)) begin
                lost_cnt_q <= lost_cnt_q + 1'b1;
            end
        end
    end

    assign err_lost_cnt_o = lost_cnt_q;
`else
    assign err_lost_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rv_iopmp_error_record.sv
// Directed self-checking bench for rv_iopmp_error_record.
// Expected counter values depend on RV_IOPMP_ERR_CNT_EN.

module tb_rv_iopmp_error_record;
    import rv_iopmp_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           txn_done;
    error_capture_t err;
    logic           intr_en;
    logic           clear;
    logic           v;
    logic [1:0]     ttype;
    logic [2:0]     etype;
    logic [7:0]     sid;
    logic [15:0]    eid;
    logic [31:0]    addr;
    logic [31:0]    addrh;
    logic           irq;
    logic [1:0]     cnt;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef RV_IOPMP_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    rv_iopmp_error_record #(
        .SID_WIDTH(8),
        .CNT_WIDTH(2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .txn_done_i     (txn_done),
        .err_interface_i(err),
        .intr_en_i      (intr_en),
        .clear_i        (clear),
        .err_v_o        (v),
        .err_ttype_o    (ttype),
        .err_etype_o    (etype),
        .err_sid_o      (sid),
        .err_eid_o      (eid),
        .err_addr_o     (addr),
        .err_addrh_o    (addrh),
        .irq_o          (irq),
        .err_lost_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        txn_done = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic set_ev(input logic [1:0] tt, input logic [2:0] et,
                          input logic [7:0] s, input logic [15:0] e,
                          input logic [31:0] a, input logic [31:0] ah);
        err.error_detected   = 1'b1;
        err.ttype            = tt;
        err.etype            = et;
        err.err_reqid.sid    = s;
        err.err_reqid.eid    = e;
        err.err_reqaddr      = a;
        err.err_reqaddrh     = ah;
        txn_done             = 1'b1;
    endtask

    function automatic logic [1:0] exp_cnt(input logic [1:0] c);
        return CNT_ON ? c : 2'd0;
    endfunction

    initial begin
        rst_n    = 1'b0;
        txn_done = 1'b0;
        err      = '0;
        intr_en  = 1'b1;
        clear    = 1'b0;

        // Reset state, with a strobe presented during reset.
        set_ev(2'd1, 3'd1, 8'h11, 16'h1, 32'h1, 32'h1);
        tick();
        tick();
        check("rst_v", v, 0);
        check("rst_irq", irq, 0);
        check("rst_sid", sid, 0);
        check("rst_addr", addr, 0);
        check("rst_cnt", cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture.
        set_ev(2'd1, 3'd2, 8'h05, 16'd3, 32'h8000_1000, 32'h1);
        tick();
        check("cap_v", v, 1);
        check("cap_irq", irq, 1);
        check("cap_ttype", ttype, 1);
        check("cap_etype", etype, 2);
        check("cap_sid", sid, 8'h05);
        check("cap_eid", eid, 3);
        check("cap_addr", addr, 32'h8000_1000);
        check("cap_addrh", addrh, 1);
        check("cap_cnt", cnt, 0);

        // First error wins: three more events.
        for (int i = 0; i < 3; i++) begin
            set_ev(2'd2, 3'd5, 8'h07, 16'hBEEF, 32'hDEAD_0000, 32'h2);
            tick();
        end
        check("fw_sid", sid, 8'h05);
        check("fw_eid", eid, 3);
        check("fw_addr", addr, 32'h8000_1000);
        check("fw_etype", etype, 2);
        check("fw_cnt", cnt, exp_cnt(2'd3));

        // Two more: five extra in total, 2-bit counter saturates.
        for (int i = 0; i < 2; i++) begin
            set_ev(2'd2, 3'd5, 8'h07, 16'hBEEF, 32'hDEAD_0000, 32'h2);
            tick();
        end
        check("sat_cnt", cnt, exp_cnt(2'd3));
        check("sat_v", v, 1);

        // Clear, then rebuild a record with counter 2.
        clear = 1'b1;
        tick();
        check("clr_v", v, 0);
        check("clr_cnt", cnt, 0);
        set_ev(2'd3, 3'd1, 8'h05, 16'd7, 32'h100, 32'h0);
        tick();
        set_ev(2'd1, 3'd1, 8'h06, 16'd8, 32'h200, 32'h0);
        tick();
        set_ev(2'd1, 3'd1, 8'h06, 16'd8, 32'h200, 32'h0);
        tick();
        check("pre_cnt", cnt, exp_cnt(2'd2));
        check("pre_sid", sid, 8'h05);

        // Simultaneous clear and error.
        set_ev(2'd2, 3'd4, 8'h09, 16'hFFFF, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        clear = 1'b1;
        tick();
        check("sim_v", v, 1);
        check("sim_sid", sid, 8'h09);
        check("sim_etype", etype, 4);
        check("sim_ttype", ttype, 2);
        check("sim_eid", eid, 16'hFFFF);
        check("sim_addrh", addrh, 32'hFFFF_FFFF);
        check("sim_cnt", cnt, 0);

        // Interrupt gating is combinational and leaves the record alone.
        intr_en = 1'b0;
        #1;
        check("gate_irq", irq, 0);
        check("gate_v", v, 1);
        intr_en = 1'b1;
        #1;
        check("ungate_irq", irq, 1);
        intr_en = 1'b0;
        clear   = 1'b1;
        tick();
        check("clr2_v", v, 0);
        check("clr2_irq", irq, 0);
        intr_en = 1'b1;

        // Error without strobe, strobe without error, clear while empty.
        set_ev(2'd1, 3'd3, 8'h22, 16'd1, 32'h1, 32'h1);
        txn_done = 1'b0;
        tick();
        check("nostrobe_v", v, 0);
        set_ev(2'd1, 3'd3, 8'h22, 16'd1, 32'h1, 32'h1);
        err.error_detected = 1'b0;
        tick();
        check("noerr_v", v, 0);
        clear = 1'b1;
        tick();
        check("clr_empty_v", v, 0);
        check("clr_empty_irq", irq, 0);

        // Asynchronous reset while held.
        set_ev(2'd3, 3'd6, 8'h0A, 16'd9, 32'h1234_5678, 32'h9);
        tick();
        check("pre_rst_v", v, 1);
        check("pre_rst_sid", sid, 8'h0A);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_v", v, 0);
        check("arst_irq", irq, 0);
        check("arst_sid", sid, 0);
        check("arst_addr", addr, 0);
        check("arst_ttype", ttype, 0);
        check("arst_cnt", cnt, 0);
        set_ev(2'd1, 3'd1, 8'h33, 16'd2, 32'h2, 32'h2);
        tick();
        check("arst_drop_v", v, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First post-reset event captured normally.
        set_ev(2'd2, 3'd7, 8'h0B, 16'd12, 32'h4000_0000, 32'h3);
        tick();
        check("post_v", v, 1);
        check("post_irq", irq, 1);
        check("post_sid", sid, 8'h0B);
        check("post_etype", etype, 7);
        check("post_addr", addr, 32'h4000_0000);
        check("post_cnt", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
